// File: rtl/pow_5_share_arbiter.sv
// Round-robin arbiter that shares one multi-cycle pow_5 unit among NUM_REQ
// requesters. Each grant issues the operand, waits for the unit (bounded by a
// timeout), and returns the result, or an error, to the granted requester.
module pow_5_share_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int W              = 18,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_n,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [W-1:0]         resp_data,
  output logic                 resp_error,
  output logic                 busy,
  output logic                 unit_run,
  output logic [W-1:0]         unit_n,
  input  logic                 unit_ready,
  input  logic [W-1:0]         unit_result
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_grant;
  logic [CNT_W-1:0]   r_cnt;
  logic [PTR_W-1:0]   w_pick;
  logic               w_found;
  logic               w_timeout;

  // The last WAIT cycle allowed before the request is declared lost.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Round-robin pick: first pending request scanning upward from pointer+1.
  always_comb begin
    logic [PTR_W-1:0] idx;
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_pick  = '0;
    w_found = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PTR_W'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_found && req_valid[idx]) begin
        w_pick  = idx;
        w_found = 1'b1;
      end
    end
  end

  // Next-state logic; ready beats timeout when both land on the same edge.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (unit_ready && w_found) w_next_state = ISSUE;
      ISSUE:   w_next_state = WAIT;
      WAIT:    if (unit_ready || w_timeout) w_next_state = RESPOND;
      RESPOND: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register; reset aborts any in-flight request immediately.
  always_ff @(posedge clock or posedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset_n) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Registered datapath and outputs, updated from the current state's action.
  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      r_ptr      <= PTR_W'(NUM_REQ - 1);
      r_grant    <= '0;
      r_cnt      <= '0;
      req_ack    <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_error <= 1'b0;
      busy       <= 1'b0;
      unit_run   <= 1'b0;
      unit_n     <= '0;
    end else begin
      req_ack    <= '0;
      resp_valid <= '0;
      unit_run   <= 1'b0;
      busy       <= (w_next_state != IDLE);
      case (r_state)
        IDLE: begin
          if (w_next_state == ISSUE) begin
            r_grant         <= w_pick;
            unit_n          <= req_n[w_pick*W +: W];
            unit_run        <= 1'b1;
            req_ack[w_pick] <= 1'b1;
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (unit_ready) begin
            resp_data           <= unit_result;
            resp_error          <= 1'b0;
            resp_valid[r_grant] <= 1'b1;
          end else if (w_timeout) begin
            resp_data           <= '0;
            resp_error          <= 1'b1;
            resp_valid[r_grant] <= 1'b1;
          end
        end
        RESPOND: begin
          r_ptr      <= r_grant;
          resp_error <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pow_5_share_arbiter.sv
// Self-checking bench for pow_5_share_arbiter: a behavioural pow_5 unit with
// programmable latency, a round-robin reference model, and directed plus
// randomized request sequences.
module tb_pow_5_share_arbiter;

  localparam int NR  = 4;
  localparam int W   = 18;
  localparam int TMO = 8;

  logic              clock;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR*W-1:0]   req_n;
  logic [NR-1:0]     req_ack;
  logic [NR-1:0]     resp_valid;
  logic [W-1:0]      resp_data;
  logic              resp_error;
  logic              busy;
  logic              unit_run;
  logic [W-1:0]      unit_n;
  logic              unit_ready;
  logic [W-1:0]      unit_result;

  int errors = 0;
  int checks = 0;
  int model_ptr = NR - 1;
  int lat = 4;
  bit never_ready = 1'b0;
  int ack_cnt[NR];
  int resp_cnt[NR];

  pow_5_share_arbiter #(.NUM_REQ(NR), .W(W), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_n(req_n),
    .req_ack(req_ack), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_error(resp_error), .busy(busy), .unit_run(unit_run), .unit_n(unit_n),
    .unit_ready(unit_ready), .unit_result(unit_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [W-1:0] pow5(input logic [W-1:0] n);
    longint unsigned x;
    x = longint'(n);
    return W'(x * x * x * x * x);
  endfunction

  // Reference round-robin: first pending requester after the last one served.
  function automatic int model_pick(input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (model_ptr + k) % NR;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behavioural pow_5 unit: accepts run while ready, ready again lat cycles later.
  logic [W-1:0] u_n;
  int           u_cnt;
  always @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      unit_ready  <= 1'b1;
      unit_result <= '0;
      u_n         <= '0;
      u_cnt       <= 0;
    end else if (unit_ready) begin
      if (unit_run) begin
        unit_ready <= 1'b0;
        u_n        <= unit_n;
        u_cnt      <= 0;
      end
    end else if (!never_ready) begin
      if (u_cnt + 1 >= lat) begin
        unit_ready  <= 1'b1;
        unit_result <= pow5(u_n);
      end else begin
        u_cnt <= u_cnt + 1;
      end
    end
  end

  // Per-cycle protocol invariants and per-requester ack/response tallies.
  always @(negedge clock) begin
    if (!reset_n) begin
      check("ack_onehot", 64'($countones(req_ack) <= 1), 64'd1);
      check("resp_onehot", 64'($countones(resp_valid) <= 1), 64'd1);
      check("run_with_ack", unit_run, |req_ack);
      check("err_needs_resp", 64'(resp_error && resp_valid == '0), 64'd0);
      for (int i = 0; i < NR; i++) begin
        ack_cnt[i]  += int'(req_ack[i]);
        resp_cnt[i] += int'(resp_valid[i]);
      end
    end
  end

  task automatic set_n(input int idx, input logic [W-1:0] n);
    req_n[idx*W +: W] = n;
  endtask

  task automatic do_reset();
    req_valid = '0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    model_ptr = NR - 1;
  endtask

  // One grant/response round against the reference model.
  task automatic service(input string tag, input bit drop, input bit exp_err,
                         input int exp_resp_steps, output int ack_steps,
                         output logic [W-1:0] got);
    int g;
    int steps;
    logic [W-1:0] n_exp;
    logic [W-1:0] d_exp;
    g = model_pick(req_valid);
    n_exp = req_n[g*W +: W];
    d_exp = exp_err ? '0 : pow5(n_exp);
    steps = 0;
    do begin @(negedge clock); steps++; end while (req_ack == '0 && steps < 400);
    ack_steps = steps;
    check({tag, "_ack"}, req_ack, NR'(1) << g);
    check({tag, "_run"}, unit_run, 1'b1);
    check({tag, "_unit_n"}, unit_n, n_exp);
    if (drop) req_valid[g] = 1'b0;
    steps = 0;
    do begin @(negedge clock); steps++; end while (resp_valid == '0 && steps < 400);
    got = resp_data;
    check({tag, "_resp"}, resp_valid, NR'(1) << g);
    check({tag, "_data"}, resp_data, d_exp);
    check({tag, "_err"}, resp_error, exp_err);
    if (exp_resp_steps >= 0) check({tag, "_resp_lat"}, steps, exp_resp_steps);
    model_ptr = g;
    @(negedge clock);
    check({tag, "_busy_low"}, busy, 1'b0);
  endtask

  initial begin
    int ast;
    int snap_a[NR];
    int snap_r[NR];
    int runs;
    logic [W-1:0] got;
    logic [NR-1:0] mask;

    for (int i = 0; i < NR; i++) begin ack_cnt[i] = 0; resp_cnt[i] = 0; end
    reset_n   = 1'b1;
    req_valid = '0;
    req_n     = '0;

    // Reset values while reset is held.
    #12;
    check("rst_ack", req_ack, 0);
    check("rst_resp", resp_valid, 0);
    check("rst_data", resp_data, 0);
    check("rst_err", resp_error, 0);
    check("rst_busy", busy, 0);
    check("rst_run", unit_run, 0);
    check("rst_unit_n", unit_n, 0);
    @(negedge clock);
    reset_n = 1'b0;

    // Single request: ack one cycle after sampling; response after
    // run-sample + unit latency + registered response.
    lat = 4;
    set_n(0, 18'd3);
    req_valid = 4'b0001;
    service("single", 1'b1, 1'b0, lat + 2, ast, got);
    check("single_ack_lat", ast, 1);
    check("single_243", got, 243);

    // All four at once right after reset: order 0,1,2,3.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      set_n(i, W'(i + 1));
      snap_a[i] = ack_cnt[i];
      snap_r[i] = resp_cnt[i];
    end
    req_valid = 4'b1111;
    service("all0", 1'b1, 1'b0, -1, ast, got); check("all0_val", got, 1);
    service("all1", 1'b1, 1'b0, -1, ast, got); check("all1_val", got, 32);
    service("all2", 1'b1, 1'b0, -1, ast, got); check("all2_val", got, 243);
    service("all3", 1'b1, 1'b0, -1, ast, got); check("all3_val", got, 1024);
    for (int i = 0; i < NR; i++) begin
      check("all_ack_once", ack_cnt[i] - snap_a[i], 1);
      check("all_resp_once", resp_cnt[i] - snap_r[i], 1);
    end

    // Fairness: 1 and 3 held continuously alternate.
    set_n(1, 18'd5);
    set_n(3, 18'd7);
    req_valid = 4'b1010;
    service("rr_a", 1'b0, 1'b0, -1, ast, got); check("rr_a_val", got, 3125);
    service("rr_b", 1'b0, 1'b0, -1, ast, got); check("rr_b_val", got, 16807);
    service("rr_c", 1'b0, 1'b0, -1, ast, got); check("rr_c_val", got, 3125);
    service("rr_d", 1'b0, 1'b0, -1, ast, got); check("rr_d_val", got, 16807);
    req_valid = '0;

    // Modulo wrap of the unit result.
    set_n(2, 18'd13);
    req_valid = 4'b0100;
    service("wrap", 1'b1, 1'b0, -1, ast, got);
    check("wrap_val", got, 109149);

    // Ready and timeout on the same edge: ready wins.
    lat = TMO - 1;
    set_n(3, 18'd2);
    req_valid = 4'b1000;
    service("tie", 1'b1, 1'b0, TMO + 1, ast, got);

    // Randomized request sets, operands and unit latencies.
    for (int t = 0; t < 12; t++) begin
      mask = NR'($urandom_range(1, (1 << NR) - 1));
      lat  = int'($urandom_range(1, 6));
      for (int i = 0; i < NR; i++) set_n(i, W'($urandom));
      req_valid = mask;
      for (int k = 0; k < $countones(mask); k++)
        service("rand", 1'b1, 1'b0, lat + 2, ast, got);
    end

    // Timeout: unit never completes, error response after TMO WAIT cycles.
    lat = 4;
    never_ready = 1'b1;
    set_n(2, 18'd9);
    req_valid = 4'b0100;
    service("tmo", 1'b1, 1'b1, TMO + 1, ast, got);
    set_n(0, 18'd10);
    req_valid = 4'b0001;
    runs = 0;
    repeat (20) begin @(negedge clock); runs += int'(unit_run); end
    check("tmo_no_issue", runs, 0);
    never_ready = 1'b0;
    service("after_tmo", 1'b1, 1'b0, -1, ast, got);
    check("after_tmo_val", got, 100000);

    // Reset during WAIT aborts the request with no response.
    snap_r[1] = resp_cnt[1];
    set_n(1, 18'd4);
    req_valid = 4'b0010;
    ast = 0;
    do begin @(negedge clock); ast++; end while (req_ack == '0 && ast < 400);
    check("abort_ack", req_ack, 4'b0010);
    req_valid = '0;
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    #1;
    check("abort_ack0", req_ack, 0);
    check("abort_resp0", resp_valid, 0);
    check("abort_run0", unit_run, 0);
    check("abort_busy0", busy, 0);
    check("abort_data0", resp_data, 0);
    check("abort_err0", resp_error, 0);
    check("abort_unit_n0", unit_n, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    model_ptr = NR - 1;
    set_n(2, 18'd6);
    set_n(3, 18'd11);
    req_valid = 4'b1100;
    service("post_rst2", 1'b1, 1'b0, -1, ast, got);
    service("post_rst3", 1'b1, 1'b0, -1, ast, got);
    check("abort_no_resp", resp_cnt[1] - snap_r[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pow_5_share_arbiter.md
Name: pow_5_share_arbiter

Overview:
- Shares one multi-cycle pow_5 sequential unit (run/ready handshake) among NUM_REQ requesters.
- Round-robin arbitration; issues n to the unit, waits for completion, returns n^5 to the granted requester.
- Includes a completion timeout that flags an error response.
- Sits between client blocks and a single pow_5 sequential instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- W, 18, operand/result width.
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT before an error response (≥2).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  reset, asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester request; held high until matching req_ack.
- req_n  input  NUM_REQ*W  operand of requester i at bits [i*W +: W].
- req_ack  output  NUM_REQ  one-cycle pulse: request i accepted.
- resp_valid  output  NUM_REQ  one-cycle pulse: response for requester i.
- resp_data  output  W  result; valid only while any resp_valid bit is high.
- resp_error  output  1  high with resp_valid if timeout occurred.
- busy  output  1  high in any state other than IDLE.
- unit_run  output  1  start pulse to the pow_5 unit.
- unit_n  output  W  operand to the pow_5 unit.
- unit_ready  input  1  unit idle / result valid.
- unit_result  input  W  unit result, valid while unit_ready high after completion.

Behaviour:
- Unit contract: unit samples unit_run on a rising edge while unit_ready=1; unit_ready is low from the next cycle until the result is valid.
- Reset (reset_n=1, asynchronous): state=IDLE; req_ack, resp_valid, resp_error, busy, unit_run = 0; unit_n, resp_data = 0; rr pointer = NUM_REQ-1, so requester 0 has top priority after reset.
- Reset mid-operation: abort immediately. No ack or response is issued for the in-flight request. The unit result is discarded.
- IDLE: at an edge where unit_ready=1 and any req_valid=1:
  - select the first set bit scanning from pointer+1 upward with wrap-around;
  - register grant index and unit_n=req_n[grant];
  - go to ISSUE.
  - Otherwise stay in IDLE, including when requests are pending but unit_ready=0.
- ISSUE (exactly one cycle): unit_run=1, req_ack[grant]=1; go to WAIT and clear the timeout counter.
- WAIT:
  - The counter increments each cycle.
  - At an edge with unit_ready=1: capture unit_result into resp_data, resp_error=0, go to RESPOND.
  - If the counter reaches TIMEOUT_CYCLES first: resp_data=0, resp_error=1, go to RESPOND.
  - If both occur on the same edge, ready wins (no error).
- RESPOND (one cycle): resp_valid[grant]=1; pointer=grant; go to IDLE.
- At most one req_ack bit and one resp_valid bit are high in any cycle. Outputs are registered.
- Latency:
  - req_valid sampled at edge E0 in IDLE → req_ack/unit_run in cycle E0..E1.
  - unit_ready sampled high at edge Ek → resp_valid in cycle Ek..Ek+1.
  - Minimum back-to-back issue spacing: 4 cycles plus unit latency.
- A requester whose req_valid stays high after its response is re-arbitrated normally and gets no priority bonus.
- req_n of non-granted requesters is ignored. The arbiter does not modify data; W-bit modulo arithmetic is the unit's.
- After a timeout, IDLE still waits for unit_ready=1 before the next issue.

Test Plan:
- Single request: req 0 valid, n=3, unit latency 4 → req_ack[0] one cycle after sampling; resp_valid[0] with resp_data=243, resp_error=0, busy low afterwards.
- All four requesters simultaneously with n=1,2,3,4 starting right after reset → service order 0,1,2,3; results 1, 32, 243, 1024; exactly one ack and one resp per request.
- Round-robin fairness: req 1 and req 3 held high continuously with n=5 and n=7 → grants alternate 1,3,1,3; responses 3125 and 16807 each time.
- Wrap/modulo: n=13 → resp_data=109149 (371293 mod 2^18).
- Timeout: unit model never raises ready, TIMEOUT_CYCLES=8 → resp_valid[grant] with resp_error=1, resp_data=0 after 8 WAIT cycles; no new unit_run until unit_ready=1.
- Reset mid-WAIT: assert reset_n during WAIT → all outputs 0 immediately, no resp_valid for the aborted request. After release, the pending req 2 is served first only if req 0 and req 1 are low (pointer reset check).
